mastermind_board_writer: RTL and testbench
==========================================

Name: mastermind_board_writer

Overview:
- Game controller that owns the 6×4 peg board and writes it. It drives the 72-bit board bus, the current row index and the INPUT-state flag, which the VGA renderer consumes.
- Takes single-cycle button pulses to edit the current guess row and scores the row against a latched secret with a multi-cycle sequential scorer.
- Sequences the game through IDLE, INPUT, SCORE, COMMIT, WIN and LOSE.

Parameters:
- ROWS, 6, number of guess rows. Fixed to match the renderer.
- COLS, 4, pegs per row. Fixed.
- CW, 3, bits per peg colour code. Fixed.

Ports:
- clk  in  1  pixel/system clock, ≈25 MHz
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a new game and latches secret_in
- secret_in  in  12  secret code; peg c at bits [c*3+:3]
- btn_left  in  1  one-cycle pulse; cursor left
- btn_right  in  1  one-cycle pulse; cursor right
- btn_up  in  1  one-cycle pulse; next colour at cursor
- btn_down  in  1  one-cycle pulse; previous colour at cursor
- btn_enter  in  1  one-cycle pulse; submit current row
- matrix_flat  out  72  board; row r at [r*12+:12], peg c at [c*3+:3], 0 = empty, 1..6 = colours
- guess_num  out  3  current row, 0..5
- q_Input  out  1  high only in INPUT
- cursor_col  out  2  peg being edited
- fb_flat  out  36  feedback; row r at [r*6+:6]; [2:0] = exact count, [5:3] = colour-only count
- game_won  out  1  high in WIN
- game_lost  out  1  high in LOSE

Behaviour:
- Reset (async, rst_n=0): state IDLE; matrix_flat=0, fb_flat=0, guess_num=0, cursor_col=0, q_Input=0, game_won=0, game_lost=0; latched secret=0. All outputs are registered.
- IDLE / WIN / LOSE:
  - start -> clear matrix_flat and fb_flat; guess_num=0, cursor_col=0.
  - Latch secret_in; any peg code of 0 or 7 is replaced by 1.
  - Go to INPUT next cycle. Buttons are ignored in these states.
- INPUT: q_Input=1. At most one action per cycle, in priority order: enter > left > right > up > down.
  - left/right: cursor_col wraps 0<->3.
  - up: peg code 0->1, 1->2 … 5->6, 6->1.
  - down: peg code 0->6, 6->5 … 2->1, 1->6.
  - enter: accepted only if all 4 pegs of row guess_num are non-zero; otherwise ignored with no state change.
  - start in INPUT: restarts the game exactly as from IDLE; takes priority over buttons.
- SCORE: 7 cycles, q_Input=0, buttons ignored.
  - Cycle 1: register exact = number of positions where guess peg == secret peg; clear total; k=1.
  - Cycles 1..6: total += min(count of k in guess, count of k in secret); k++.
  - All counts are 3-bit; total ≤ 4, no overflow.
- COMMIT: 1 cycle.
  - Write fb_flat row guess_num: [2:0]=exact, [5:3]=total−exact.
  - If exact==4: WIN, game_won=1.
  - Else if guess_num==5: LOSE, game_lost=1.
  - Else guess_num++, cursor_col=0, back to INPUT.
- Latency: enter accepted at edge N -> fb_flat updated and next state entered at edge N+8. q_Input is low for edges N+1..N+7 and high again from edge N+8 if play continues.
- start during SCORE or COMMIT is ignored.
- Reset mid-score aborts immediately to the reset values.
- guess_num never exceeds 5; matrix rows above guess_num remain 0.

Optional Feature:
- MM_AUTOFILL_EN
  - Defined: on COMMIT to the next row, that row is pre-loaded with the just-scored guess, so pegs start non-zero.
  - Undefined: the new row stays all-zero (empty).
  - Scoring and latency are identical in both builds.

Test Plan:
- Reset with rst_n=0 mid-game -> all outputs 0, state IDLE; the next start enters INPUT with q_Input=1 one cycle later.
- start with secret 1,2,3,4; press up×1/×2/×3/×4 with right between pegs; enter -> 8 cycles later fb_flat[5:0]=6'b000_100, game_won=1, q_Input=0.
- Secret 1,1,2,2, guess 2,2,1,1 -> fb row0 exact=0, colour-only=4; guess_num becomes 1, cursor_col=0.
- Enter with peg 3 empty -> no state change, q_Input stays 1. Left at col 0 -> col 3. Up at code 6 -> 1. Down at code 1 -> 6. Enter and up in the same cycle -> only enter acts.
- Six wrong guesses of 5,5,5,5 against secret 1,2,3,4 -> all six fb rows = 0; game_lost=1, guess_num=5; further enter ignored; start clears the board.
- Secret_in containing 0 and 7 -> latched as 1. Build with MM_AUTOFILL_EN -> row1 equals row0 immediately after COMMIT; without it row1 = 0.

Source files
------------

// File: rtl/mastermind_board_writer.sv
// Mastermind game controller: owns the 6x4 peg board, edits and scores guesses.
// Define MM_AUTOFILL_EN to pre-load each new row with the previous guess.
module mastermind_board_writer #(
  parameter int ROWS = 6,
  parameter int COLS = 4,
  parameter int CW   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [COLS*CW-1:0]       secret_in,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_enter,
  output logic [ROWS*COLS*CW-1:0]  matrix_flat,
  output logic [2:0]               guess_num,
  output logic                     q_Input,
  output logic [1:0]               cursor_col,
  output logic [ROWS*6-1:0]        fb_flat,
  output logic                     game_won,
  output logic                     game_lost
);

  localparam int RW = COLS * CW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INPUT,
    S_SCORE,
    S_COMMIT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t state_q, state_d;

  logic [RW-1:0] secret_q;
  logic [RW-1:0] secret_fix;
  logic [RW-1:0] row_cur;
  logic [CW-1:0] peg_cur;
  logic [CW-1:0] peg_up;
  logic [CW-1:0] peg_dn;
  logic [2:0]    exact_q, total_q, k_q, sc_cnt_q;
  logic [2:0]    exact_c, cnt_g, cnt_s, min_c;
  logic          row_full;
  logic          can_start;
  logic          q_input_d, won_d, lost_d;
  int            row_base, peg_base;

  assign row_base = int'(guess_num) * RW;
  assign peg_base = row_base + int'(cursor_col) * CW;
  assign row_cur  = matrix_flat[row_base +: RW];
  assign peg_cur  = row_cur[int'(cursor_col)*CW +: CW];
  assign peg_up   = (peg_cur == 3'd6) ? 3'd1 : peg_cur + 3'd1;
  assign peg_dn   = (peg_cur <= 3'd1) ? 3'd6 : peg_cur - 3'd1;

  assign can_start = start && (state_q == S_IDLE || state_q == S_INPUT
                            || state_q == S_WIN  || state_q == S_LOSE);

  // Codes 0 and 7 are not colours; fold them onto colour 1.
  always_comb begin
    secret_fix = '0;
    for (int c = 0; c < COLS; c++) begin
      if (secret_in[c*CW +: CW] == 3'd0 || secret_in[c*CW +: CW] == 3'd7)
        secret_fix[c*CW +: CW] = 3'd1;
      else
        secret_fix[c*CW +: CW] = secret_in[c*CW +: CW];
    end
  end

  always_comb begin
    row_full = 1'b1;
    exact_c  = '0;
    cnt_g    = '0;
    cnt_s    = '0;
    for (int c = 0; c < COLS; c++) begin
      if (row_cur[c*CW +: CW] == 3'd0)
        row_full = 1'b0;
      if (row_cur[c*CW +: CW] == secret_q[c*CW +: CW])
        exact_c = exact_c + 3'd1;
      if (row_cur[c*CW +: CW] == k_q)
        cnt_g = cnt_g + 3'd1;
      if (secret_q[c*CW +: CW] == k_q)
        cnt_s = cnt_s + 3'd1;
    end
    min_c = (cnt_g < cnt_s) ? cnt_g : cnt_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start)
          state_d = S_INPUT;
      end
      S_INPUT: begin
        if (start)
          state_d = S_INPUT;
        else if (btn_enter && row_full)
          state_d = S_SCORE;
      end
      S_SCORE: begin
        if (sc_cnt_q == 3'd6)
          state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (exact_q == 3'd4)
          state_d = S_WIN;
        else if (guess_num == 3'(ROWS - 1))
          state_d = S_LOSE;
        else
          state_d = S_INPUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    q_input_d = (state_d == S_INPUT);
    won_d     = (state_d == S_WIN);
    lost_d    = (state_d == S_LOSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_Input   <= 1'b0;
      game_won  <= 1'b0;
      game_lost <= 1'b0;
    end else begin
      q_Input   <= q_input_d;
      game_won  <= won_d;
      game_lost <= lost_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matrix_flat <= '0;
      fb_flat     <= '0;
      guess_num   <= '0;
      cursor_col  <= '0;
      secret_q    <= '0;
      exact_q     <= '0;
      total_q     <= '0;
      k_q         <= '0;
      sc_cnt_q    <= '0;
    end else if (can_start) begin
      matrix_flat <= '0;
      fb_flat     <= '0;
      guess_num   <= '0;
      cursor_col  <= '0;
      secret_q    <= secret_fix;
    end else begin
      unique case (state_q)
        S_INPUT: begin
          if (btn_enter) begin
            k_q      <= 3'd1;
            sc_cnt_q <= '0;
          end else if (btn_left) begin
            cursor_col <= cursor_col - 2'd1;
          end else if (btn_right) begin
            cursor_col <= cursor_col + 2'd1;
          end else if (btn_up) begin
            matrix_flat[peg_base +: CW] <= peg_up;
          end else if (btn_down) begin
            matrix_flat[peg_base +: CW] <= peg_dn;
          end
        end
        S_SCORE: begin
          // First cycle latches exact and restarts the colour total.
          if (sc_cnt_q == 3'd0) begin
            exact_q <= exact_c;
            total_q <= min_c;
          end else if (sc_cnt_q <= 3'd5) begin
            total_q <= total_q + min_c;
          end
          k_q      <= k_q + 3'd1;
          sc_cnt_q <= sc_cnt_q + 3'd1;
        end
        S_COMMIT: begin
          fb_flat[int'(guess_num)*6 +: 6] <= {total_q - exact_q, exact_q};
          if (exact_q != 3'd4 && guess_num != 3'(ROWS - 1)) begin
`ifdef MM_AUTOFILL_EN
            matrix_flat[row_base + RW +: RW] <= row_cur;
`endif
            guess_num  <= guess_num + 3'd1;
            cursor_col <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mastermind_board_writer.sv
// Randomized bench for mastermind_board_writer against a game-level model.
// Build with +define+MM_AUTOFILL_EN to check the row pre-load variant.
module tb_mastermind_board_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] secret_in;
  logic        btn_left, btn_right, btn_up, btn_down, btn_enter;
  logic [71:0] matrix_flat;
  logic [2:0]  guess_num;
  logic        q_Input;
  logic [1:0]  cursor_col;
  logic [35:0] fb_flat;
  logic        game_won, game_lost;

  mastermind_board_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .secret_in(secret_in),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_enter(btn_enter),
    .matrix_flat(matrix_flat), .guess_num(guess_num), .q_Input(q_Input),
    .cursor_col(cursor_col), .fb_flat(fb_flat),
    .game_won(game_won), .game_lost(game_lost)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] B_NONE  = 6'h00;
  localparam logic [5:0] B_START = 6'h01;
  localparam logic [5:0] B_L     = 6'h02;
  localparam logic [5:0] B_R     = 6'h04;
  localparam logic [5:0] B_U     = 6'h08;
  localparam logic [5:0] B_D     = 6'h10;
  localparam logic [5:0] B_E     = 6'h20;

  int n_chk = 0;
  int n_fail = 0;

  // Model: 0 idle, 1 input, 2 busy scoring, 3 won, 4 lost
  int m_st, m_cnt, m_gn, m_cur;
  int m_b[6][4];
  int m_sec[4];
  int m_ex[6];
  int m_co[6];

  task automatic check(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] mk(input int a, input int b,
                                     input int c, input int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_gn = 0; m_cur = 0;
    for (int r = 0; r < 6; r++) begin
      m_ex[r] = 0; m_co[r] = 0;
      for (int c = 0; c < 4; c++) m_b[r][c] = 0;
    end
    for (int c = 0; c < 4; c++) m_sec[c] = 0;
  endtask

  task automatic m_score();
    int ex, tot, cg, cs;
    ex = 0; tot = 0;
    for (int c = 0; c < 4; c++) if (m_b[m_gn][c] == m_sec[c]) ex++;
    for (int k = 1; k <= 6; k++) begin
      cg = 0; cs = 0;
      for (int c = 0; c < 4; c++) begin
        if (m_b[m_gn][c] == k) cg++;
        if (m_sec[c] == k) cs++;
      end
      tot += (cg < cs) ? cg : cs;
    end
    m_ex[m_gn] = ex;
    m_co[m_gn] = tot - ex;
    if (ex == 4) m_st = 3;
    else if (m_gn == 5) m_st = 4;
    else begin
`ifdef MM_AUTOFILL_EN
      for (int c = 0; c < 4; c++) m_b[m_gn+1][c] = m_b[m_gn][c];
`endif
      m_gn++; m_cur = 0; m_st = 1;
    end
  endtask

  task automatic m_step(input logic [5:0] b, input logic [11:0] sin);
    logic [2:0] v;
    bit full;
    if (m_st != 2 && b[0]) begin
      for (int r = 0; r < 6; r++) begin
        m_ex[r] = 0; m_co[r] = 0;
        for (int c = 0; c < 4; c++) m_b[r][c] = 0;
      end
      for (int c = 0; c < 4; c++) begin
        v = sin[c*3 +: 3];
        m_sec[c] = (v == 0 || v == 7) ? 1 : int'(v);
      end
      m_gn = 0; m_cur = 0; m_st = 1;
    end else if (m_st == 1) begin
      if (b[5]) begin
        full = 1;
        for (int c = 0; c < 4; c++) if (m_b[m_gn][c] == 0) full = 0;
        if (full) begin m_st = 2; m_cnt = 0; end
      end else if (b[1]) m_cur = (m_cur + 3) % 4;
      else if (b[2]) m_cur = (m_cur + 1) % 4;
      else if (b[3])
        m_b[m_gn][m_cur] = (m_b[m_gn][m_cur] == 6) ? 1 : m_b[m_gn][m_cur] + 1;
      else if (b[4])
        m_b[m_gn][m_cur] = (m_b[m_gn][m_cur] <= 1) ? 6 : m_b[m_gn][m_cur] - 1;
    end else if (m_st == 2) begin
      m_cnt++;
      if (m_cnt == 8) m_score();
    end
  endtask

  task automatic check_all();
    logic [71:0] em;
    logic [35:0] ef;
    em = '0; ef = '0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) em[r*12 + c*3 +: 3] = 3'(m_b[r][c]);
      ef[r*6 +: 6] = {3'(m_co[r]), 3'(m_ex[r])};
    end
    check("matrix", 72'(matrix_flat), em);
    check("fb", 72'(fb_flat), 72'(ef));
    check("guess_num", 72'(guess_num), 72'(m_gn));
    check("cursor", 72'(cursor_col), 72'(m_cur));
    check("q_input", 72'(q_Input), 72'(m_st == 1));
    check("won", 72'(game_won), 72'(m_st == 3));
    check("lost", 72'(game_lost), 72'(m_st == 4));
  endtask

  task automatic step(input logic [5:0] b, input logic [11:0] sin);
    start = b[0]; btn_left = b[1]; btn_right = b[2];
    btn_up = b[3]; btn_down = b[4]; btn_enter = b[5];
    secret_in = sin;
    m_step(b, sin);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic set_row(input logic [11:0] g);
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4 && m_cur != c; i++) step(B_R, 12'h0);
      for (int i = 0; i < 7 && m_b[m_gn][c] != int'(g[c*3 +: 3]); i++)
        step(B_U, 12'h0);
    end
  endtask

  task automatic guess_row(input logic [11:0] g);
    set_row(g);
    step(B_E, 12'h0);
    repeat (8) step(B_NONE, 12'h0);
  endtask

  int r;
  logic [5:0] b;

  initial begin
    start = 0; btn_left = 0; btn_right = 0; btn_up = 0;
    btn_down = 0; btn_enter = 0; secret_in = '0; rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step(B_NONE, 12'h0);

    // Direct win on first row
    step(B_START, mk(1, 2, 3, 4));
    check("start_q", 72'(q_Input), 72'd1);
    guess_row(mk(1, 2, 3, 4));
    check("win_fb", 72'(fb_flat[5:0]), 72'(6'b000_100));
    check("win_flag", 72'(game_won), 72'd1);
    check("win_q", 72'(q_Input), 72'd0);

    // All colours right, none in place
    step(B_START, mk(1, 1, 2, 2));
    guess_row(mk(2, 2, 1, 1));
    check("swap_fb", 72'(fb_flat[5:0]), 72'(6'b100_000));
    check("swap_gn", 72'(guess_num), 72'd1);
    check("swap_cur", 72'(cursor_col), 72'd0);
`ifdef MM_AUTOFILL_EN
    check("row1_fill", 72'(matrix_flat[23:12]), 72'(mk(2, 2, 1, 1)));
`else
    check("row1_zero", 72'(matrix_flat[23:12]), 72'd0);
    step(B_E, 12'h0);
    check("enter_empty", 72'(q_Input), 72'd1);
`endif
    step(B_L, 12'h0);
    check("left_wrap", 72'(cursor_col), 72'd3);
    set_row(mk(4, 4, 4, 6));
    step(B_U, 12'h0);
    check("up_wrap", 72'(matrix_flat[23:21]), 72'd1);
    step(B_D, 12'h0);
    check("down_wrap", 72'(matrix_flat[23:21]), 72'd6);
    step(B_E | B_U, 12'h0);
    check("enter_prio", 72'(matrix_flat[23:21]), 72'd6);
    repeat (8) step(B_NONE, 12'h0);

    // Six misses lose
    step(B_START, mk(1, 2, 3, 4));
    repeat (6) guess_row(mk(5, 5, 5, 5));
    check("lose_flag", 72'(game_lost), 72'd1);
    check("lose_gn", 72'(guess_num), 72'd5);
    check("lose_fb", 72'(fb_flat), 72'd0);
    step(B_E, 12'h0);
    step(B_NONE, 12'h0);
    check("lose_hold", 72'(game_lost), 72'd1);
    step(B_START, mk(1, 2, 3, 4));
    check("restart_clr", 72'(matrix_flat), 72'd0);

    // Illegal secret codes fold to 1
    step(B_START, mk(0, 7, 3, 7));
    guess_row(mk(1, 1, 3, 1));
    check("fold_win", 72'(game_won), 72'd1);

    // Reset in the middle of scoring
    step(B_START, mk(2, 3, 4, 5));
    set_row(mk(6, 6, 6, 6));
    step(B_E, 12'h0);
    repeat (3) step(B_NONE, 12'h0);
    do_reset();
    step(B_START, mk(2, 3, 4, 5));
    check("post_rst_q", 72'(q_Input), 72'd1);

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) b = B_START;
      else if (r < 14) b = B_E;
      else if (r < 26) b = B_L;
      else if (r < 38) b = B_R;
      else if (r < 70) b = B_U;
      else if (r < 85) b = B_D;
      else if (r < 92) b = 6'($urandom);
      else b = B_NONE;
      step(b, 12'($urandom));
      if (i % 1000 == 777) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
